// File: rtl/a2d_arb_if.sv
// a2d_arb_if: bundles the requester-side and A2D_intf-side signals of the
// A2D arbiter.
//   req/req_chnnl       requesters -> arbiter (level request, 3-bit channel each)
//   gnt/done/err        arbiter -> requesters (grant, completion pulse, timeout pulse)
//   res_out/busy        arbiter -> requesters (last good result, not-idle flag)
//   strt_cnv/chnnl      arbiter -> A2D_intf
//   cnv_cmplt/res       A2D_intf -> arbiter
// slave is the arbiter's view; master is the requester/A2D_intf side.
interface a2d_arb_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0][2:0] req_chnnl;   // requester i occupies bits [3i+2:3i]
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      done;
  logic                    err;
  logic [11:0]             res_out;
  logic                    busy;
  logic                    strt_cnv;
  logic [2:0]              chnnl;
  logic                    cnv_cmplt;
  logic [11:0]             res;

  modport slave (
    input  req, req_chnnl, cnv_cmplt, res,
    output gnt, done, err, res_out, busy, strt_cnv, chnnl
  );

  modport master (
    output req, req_chnnl, cnv_cmplt, res,
    input  gnt, done, err, res_out, busy, strt_cnv, chnnl
  );
endinterface

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin share of one A2D_intf among NUM_REQ requesters.
// Each granted requester gets one conversion on its channel; a watchdog
// aborts a conversion that never reports cnv_cmplt within TMO_CYCLES.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          a2d_arb_if.slave (requester and A2D_intf signals)
// Parameters:
//   NUM_REQ      2..4 requesters
//   TMO_CYCLES   WAIT cycles without cnv_cmplt before abort
module a2d_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int TMO_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  a2d_arb_if.slave    bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = ($clog2(TMO_CYCLES) > 12) ? $clog2(TMO_CYCLES) : 12;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [PW-1:0]      ptr;        // last served requester
  logic [PW-1:0]      win;        // requester owning the current transaction
  logic [PW-1:0]      nxt_win;
  logic               nxt_found;
  logic [PW:0]        sum;
  logic [WW-1:0]      wdog;
  logic               tmo;
  logic [NUM_REQ-1:0] gnt_q;
  logic [2:0]         chnnl_q;
  logic [11:0]        res_q;

  // Round-robin search starting just after ptr. sum is one bit wider than
  // ptr so ptr+NUM_REQ cannot wrap before the modulo correction.
  always_comb begin
    nxt_found = 1'b0;
    nxt_win   = '0;
    sum       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      if (!nxt_found && bus.req[sum[PW-1:0]]) begin
        nxt_found = 1'b1;
        nxt_win   = sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= PW'(NUM_REQ-1);
      win     <= '0;
      wdog    <= '0;
      tmo     <= 1'b0;
      gnt_q   <= '0;
      chnnl_q <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: if (nxt_found) begin
          win     <= nxt_win;
          gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << nxt_win;
          chnnl_q <= bus.req_chnnl[nxt_win];
          state   <= START;
        end
        START: begin
          wdog  <= '0;
          tmo   <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          // A completion on the last watchdog cycle still counts as success.
          if (bus.cnv_cmplt) begin
            res_q <= bus.res;
            state <= DONE;
          end else if (wdog == WW'(TMO_CYCLES-1)) begin
            tmo   <= 1'b1;
            state <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          ptr   <= win;
          tmo   <= 1'b0;
          gnt_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse outputs decode straight from state so an async reset clears them
  // in the same instant as the FSM.
  assign bus.gnt      = gnt_q;
  assign bus.done     = (state == DONE) ? gnt_q : '0;
  assign bus.err      = (state == DONE) && tmo;
  assign bus.busy     = (state != IDLE);
  assign bus.strt_cnv = (state == START);
  assign bus.chnnl    = chnnl_q;
  assign bus.res_out  = res_q;
endmodule

// File: tb/tb_a2d_arbiter.sv
module tb_a2d_arbiter;
  localparam int NR  = 3;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  a2d_arb_if #(.NUM_REQ(NR)) bus();
  a2d_arbiter #(.NUM_REQ(NR), .TMO_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int w; int ch; int cy; } gexp_t;
  typedef struct { int w; int ch; int res; int err; int cy; } dexp_t;
  gexp_t qg[$];
  dexp_t qd[$];
  int    order_log[$];

  // transaction-level reference state
  int ptr_m, cur_w, cur_ch, last_res, ndone;
  bit inflight, hold_all;
  int force_lat = -1;   // 0 = never complete, >0 = fixed latency
  int force_res = -1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic int pick(logic [NR-1:0] m, int p);
    for (int o = 1; o <= NR; o++) begin
      int k;
      k = (p + o) % NR;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  task automatic predict(int dly);
    gexp_t g;
    cur_w  = pick(bus.req, ptr_m);
    cur_ch = int'(bus.req_chnnl[cur_w]);
    g.w = cur_w; g.ch = cur_ch; g.cy = cyc + dly;
    qg.push_back(g);
    inflight = 1'b1;
  endtask

  task automatic raise_some();
    for (int i = 0; i < NR; i++)
      if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
        bus.req[i]       = 1'b1;
        bus.req_chnnl[i] = 3'($urandom_range(0, 7));
      end
  endtask

  task automatic check_reset(string tag);
    chk({tag, " gnt"},      int'(bus.gnt), 0);
    chk({tag, " done"},     int'(bus.done), 0);
    chk({tag, " err"},      int'(bus.err), 0);
    chk({tag, " res_out"},  int'(bus.res_out), 0);
    chk({tag, " busy"},     int'(bus.busy), 0);
    chk({tag, " strt_cnv"}, int'(bus.strt_cnv), 0);
    chk({tag, " chnnl"},    int'(bus.chnnl), 0);
  endtask

  // A2D_intf model: fixed/random latency, occasional timeout, spurious
  // cnv_cmplt while idle and in the START cycle.
  bit active;
  int cnt, val;
  always @(negedge clk) begin
    int lat, v;
    dexp_t d;
    if (!rst_n) begin
      active = 1'b0;
      bus.cnv_cmplt = 1'b0;
      bus.res = '0;
    end else if (bus.strt_cnv) begin
      lat = (force_lat >= 0) ? force_lat
          : (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 64)));
      v = (force_res >= 0) ? force_res : int'($urandom_range(0, 4095));
      force_lat = -1;
      force_res = -1;
      d.w = cur_w; d.ch = cur_ch;
      if (lat == 0) begin
        d.res = last_res; d.err = 1; d.cy = cyc + TMO + 1;
      end else begin
        last_res = v;
        d.res = v; d.err = 0; d.cy = cyc + lat + 1;
      end
      qd.push_back(d);
      active = (lat != 0);
      cnt = lat;
      val = v;
      bus.cnv_cmplt = ($urandom_range(0, 3) == 0);
      bus.res = 12'($urandom_range(0, 4095));
    end else if (active) begin
      cnt--;
      if (cnt == 0) begin
        bus.cnv_cmplt = 1'b1;
        bus.res = 12'(val);
        active = 1'b0;
      end else begin
        bus.cnv_cmplt = 1'b0;
        bus.res = 12'($urandom_range(0, 4095));
      end
    end else if (!bus.busy && $urandom_range(0, 7) == 0) begin
      bus.cnv_cmplt = 1'b1;
      bus.res = 12'($urandom_range(0, 4095));
    end else begin
      bus.cnv_cmplt = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT starts or finishes.
  always @(negedge clk) begin
    gexp_t g;
    dexp_t d;
    if (rst_n) begin
      if (bus.strt_cnv) begin
        for (int i = 0; i < NR; i++) if (bus.gnt[i]) order_log.push_back(i);
        if (qg.size() == 0) fail("unexpected strt_cnv");
        else begin
          g = qg.pop_front();
          chk("gnt", int'(bus.gnt), 1 << g.w);
          chk("chnnl at start", int'(bus.chnnl), g.ch);
          chk("start cycle", cyc, g.cy);
        end
      end
      if (bus.done != '0) begin
        if (qd.size() == 0) fail("unexpected done");
        else begin
          d = qd.pop_front();
          chk("done", int'(bus.done), 1 << d.w);
          chk("err", int'(bus.err), d.err);
          chk("res_out", int'(bus.res_out), d.res);
          chk("chnnl at done", int'(bus.chnnl), d.ch);
          chk("done cycle", cyc, d.cy);
        end
      end else if (bus.err) fail("err without done");
    end
  end

  task automatic run(int ntx, int budget);
    int target, t;
    target = ndone + ntx;
    t = 0;
    while (ndone < target && t < budget) begin
      @(negedge clk);
      t++;
      if (bus.done != '0) begin
        ndone++;
        ptr_m = cur_w;
        inflight = 1'b0;
        if (!hold_all) begin
          if (bus.req[cur_w] && $urandom_range(0, 3) != 0) bus.req[cur_w] = 1'b0;
          raise_some();
        end
        if (bus.req != '0) predict(2);
      end else if (!inflight) begin
        if ($urandom_range(0, 2) == 0) raise_some();
        if (bus.req != '0) predict(1);
      end else if (bus.busy && !hold_all) begin
        if ($urandom_range(0, 5) == 0) bus.req_chnnl[cur_w] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) bus.req[cur_w] = 1'b0;
        if ($urandom_range(0, 5) == 0) raise_some();
      end
    end
    if (ndone < target) fail("timeout waiting for done");
  endtask

  initial begin
    bus.req = '0;
    bus.req_chnnl = '0;
    ptr_m = NR - 1; last_res = 0; ndone = 0; inflight = 1'b0; hold_all = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // single requester, fixed 40-cycle conversion
    @(negedge clk);
    bus.req_chnnl[1] = 3'd5;
    bus.req = 3'b010;
    force_lat = 40;
    force_res = 12'hA5C;
    predict(1);
    run(1, 200);

    // forced timeout, then normal service
    force_lat = 0;
    run(3, 600);

    run(60, 20000);

    // reset in the middle of WAIT
    if (!inflight) begin
      bus.req[1] = 1'b1;
      predict(1);
    end
    force_lat = 50;
    for (int t = 0; t < 200 && !bus.strt_cnv; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mid-wait reset");
    qg.delete();
    qd.delete();
    ptr_m = NR - 1; last_res = 0; inflight = 1'b0;
    repeat (2) @(negedge clk);

    // all requesters held: strict rotation from index 0
    bus.req = 3'b111;
    hold_all = 1'b1;
    order_log.delete();
    rst_n = 1'b1;
    predict(1);
    run(6, 1000);
    chk("rotation length", order_log.size(), 6);
    for (int i = 0; i < 6 && i < order_log.size(); i++)
      chk("rotation order", order_log[i], i % NR);
    hold_all = 1'b0;

    @(negedge clk);
    chk("done queue drained", qd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
